demod_arbiter: RTL and testbench
================================

# demod_arbiter

Packet-level round-robin controller that shares one FM demodulation datapath (CORDIC angle → phase-difference stage) between two AXI-Stream I/Q channels. It grants one channel per packet, forwards that packet to the datapath, and routes the returned result stream to a single tagged output. Between packets it drains the datapath and pulses its reset, so the differentiator's stored angle never carries over from one channel to the other. It sits between the two channel front-ends and the shared demodulator.

## Interface
- DATA_W, 32, tdata width on all streams
- s00_axis_aclk  in  1  clock for all logic
- s00_axis_aresetn  in  1  asynchronous, active-low reset
- s00_axis_tvalid / s00_axis_tready / s00_axis_tdata / s00_axis_tlast  in/out/in/in  1/1/DATA_W/1  channel 0 input stream
- s01_axis_tvalid / s01_axis_tready / s01_axis_tdata / s01_axis_tlast  in/out/in/in  1/1/DATA_W/1  channel 1 input stream
- m00_axis_tvalid / m00_axis_tready / m00_axis_tdata / m00_axis_tlast  out/in/out/out  1/1/DATA_W/1  stream to shared datapath
- s02_axis_tvalid / s02_axis_tready / s02_axis_tdata / s02_axis_tlast  in/out/in/in  1/1/DATA_W/1  result stream from datapath
- m01_axis_tvalid / m01_axis_tready / m01_axis_tdata / m01_axis_tlast  out/in/out/out  1/1/DATA_W/1  routed result stream
- m01_axis_tuser  out  1  owning channel of the current m01 beat
- dp_aresetn  out  1  registered, active-low synchronous reset to the datapath

## Operation
- FSM states: IDLE, XFER, DRAIN, CLEAR. Registers: state, owner (1 bit), last_grant (1 bit), dp_aresetn.
- IDLE: if any sNN_axis_tvalid is high, grant a channel and go to XFER.
  - Only one requesting: grant that channel.
  - Both requesting: grant channel != last_grant.
  - Write the grant to owner.
- XFER: m00 is a combinational mux of the owner's stream (tvalid, tdata, tlast; the owner's tready = m00_axis_tready). The non-owner's tready is 0.
  - On an accepted beat with tlast: go to DRAIN.
- XFER and DRAIN: s02 passes combinationally to m01 (s02_axis_tready = m01_axis_tready). m01_axis_tuser = owner.
  - DRAIN: m00_axis_tvalid = 0 and both input treadys are 0.
  - An accepted s02 beat with tlast (in XFER or DRAIN) ends the packet. Go to CLEAR; if this happens in XFER, the input tlast has necessarily already been accepted.
- CLEAR: dp_aresetn = 0 for exactly this one cycle. last_grant <= owner. Go to IDLE.
- Outside XFER/DRAIN: m01_axis_tvalid = 0 and s02_axis_tready = 0.
- Only one packet is ever in flight, so no tag FIFO is needed. tdata is never modified.

## Timing
- Reset (async assert, sync release) values:
  - state = IDLE, owner = 0, last_grant = 1 (channel 0 wins the first tie).
  - dp_aresetn = 0 while reset is held, then 1 from the first clock after release.
  - All treadys = 0, m00/m01 tvalid = 0, m01_axis_tuser = 0.
- Grant latency: tvalid seen in IDLE at cycle N → first beat can be accepted at cycle N+1.
- Forward and return paths add 0 cycles (combinational). Demodulator latency is set by the datapath.
- Inter-packet gap: return tlast accepted at cycle T → CLEAR at T+1 → IDLE at T+2 → earliest next input beat at T+3.
- A request arriving during DRAIN or CLEAR waits and is served in IDLE. Packets are never interleaved mid-packet.
- Input tvalid may drop mid-packet. The FSM stays in XFER with no timeout.
- Backpressure on m01 stalls s02 and therefore the datapath. m00 may be stalled by the datapath indefinitely.
- Reset asserted mid-packet: return immediately to reset values. Any partial packet is discarded by the upstream and downstream owners.

## Test plan
- Reset, then ch0 sends a 4-beat packet (angles 0x1000, 0x2000, 0x3000, 0x4000) with a 1-cycle datapath model → m00 carries the 4 beats unchanged, m01 shows 4 beats with tuser = 0 and tlast on the 4th, dp_aresetn is low for exactly 1 cycle after, and the next grant comes 3 cycles after the return tlast.
- Both channels continuously valid with 3-beat packets → grants alternate ch0, ch1, ch0, ch1, tuser matches on every beat, and no beat from the non-owner is accepted (its tready stays 0).
- ch1 asserts tvalid while ch0's packet is in DRAIN → ch1 is granted only from IDLE after CLEAR, and its first m00 beat follows the CLEAR cycle.
- m01_axis_tready held low for 5 cycles mid-result → s02_axis_tready is low for the same 5 cycles, no beat is lost or duplicated, and tdata order is preserved.
- Async reset asserted during XFER on beat 2 of 4 → all outputs take reset values without waiting for a clock edge, and after release ch0 wins a tie (last_grant = 1).
- 1-beat packet (tvalid and tlast together) on ch1 only → full IDLE→XFER→DRAIN→CLEAR→IDLE sequence, tuser = 1, last_grant = 1 afterwards.

Source files
------------

// File: rtl/demod_arbiter.sv
// Packet-level round-robin arbiter sharing one FM demodulation datapath between two
// AXI-Stream I/Q channels; routes results back tagged with the owning channel.
module demod_arbiter #(
    parameter int DATA_W = 32
) (
    input  logic              s00_axis_aclk,
    input  logic              s00_axis_aresetn,

    input  logic              s00_axis_tvalid,
    output logic              s00_axis_tready,
    input  logic [DATA_W-1:0] s00_axis_tdata,
    input  logic              s00_axis_tlast,

    input  logic              s01_axis_tvalid,
    output logic              s01_axis_tready,
    input  logic [DATA_W-1:0] s01_axis_tdata,
    input  logic              s01_axis_tlast,

    output logic              m00_axis_tvalid,
    input  logic              m00_axis_tready,
    output logic [DATA_W-1:0] m00_axis_tdata,
    output logic              m00_axis_tlast,

    input  logic              s02_axis_tvalid,
    output logic              s02_axis_tready,
    input  logic [DATA_W-1:0] s02_axis_tdata,
    input  logic              s02_axis_tlast,

    output logic              m01_axis_tvalid,
    input  logic              m01_axis_tready,
    output logic [DATA_W-1:0] m01_axis_tdata,
    output logic              m01_axis_tlast,
    output logic              m01_axis_tuser,

    output logic              dp_aresetn
);

    // Handshake: a beat transfers on a rising clock edge where tvalid and tready are both
    // high; a source holds tvalid/tdata/tlast until accepted, a sink may toggle tready freely.

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        XFER  = 2'd1,
        DRAIN = 2'd2,
        CLEAR = 2'd3
    } state_t;

    state_t state_q, state_d;
    logic   owner_q, owner_d;
    logic   last_grant_q, last_grant_d;
    logic   dp_aresetn_q, dp_aresetn_d;

    logic   in_xfer;
    logic   pkt_active;
    logic   grant;
    logic   in_last_acc;
    logic   ret_last_acc;

    always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
        if (!s00_axis_aresetn) begin
            state_q      <= IDLE;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            dp_aresetn_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            dp_aresetn_q <= dp_aresetn_d;
        end
    end

    always_comb begin
        in_xfer    = (state_q == XFER);
        pkt_active = (state_q == XFER) || (state_q == DRAIN);

        // Forward path: owner's stream muxed onto the datapath input, only while in XFER.
        m00_axis_tvalid = 1'b0;
        m00_axis_tdata  = owner_q ? s01_axis_tdata : s00_axis_tdata;
        m00_axis_tlast  = owner_q ? s01_axis_tlast : s00_axis_tlast;
        if (in_xfer) begin
            m00_axis_tvalid = owner_q ? s01_axis_tvalid : s00_axis_tvalid;
        end
        s00_axis_tready = in_xfer && !owner_q && m00_axis_tready;
        s01_axis_tready = in_xfer &&  owner_q && m00_axis_tready;

        // Return path: results pass straight through for the whole packet lifetime.
        m01_axis_tvalid = pkt_active && s02_axis_tvalid;
        m01_axis_tdata  = s02_axis_tdata;
        m01_axis_tlast  = s02_axis_tlast;
        m01_axis_tuser  = pkt_active && owner_q;
        s02_axis_tready = pkt_active && m01_axis_tready;

        dp_aresetn = dp_aresetn_q;

        in_last_acc  = m00_axis_tvalid && m00_axis_tready && m00_axis_tlast;
        ret_last_acc = m01_axis_tvalid && m01_axis_tready && s02_axis_tlast;
    end

    always_comb begin
        // A tie goes to the channel that was not served last.
        if (s00_axis_tvalid && s01_axis_tvalid) begin
            grant = !last_grant_q;
        end else if (s00_axis_tvalid) begin
            grant = 1'b0;
        end else begin
            grant = 1'b1;
        end
    end

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;

        case (state_q)
            IDLE: begin
                if (s00_axis_tvalid || s01_axis_tvalid) begin
                    owner_d = grant;
                    state_d = XFER;
                end
            end
            XFER: begin
                // Return tlast can only follow the input tlast, so it takes priority.
                if (ret_last_acc) begin
                    state_d = CLEAR;
                end else if (in_last_acc) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (ret_last_acc) begin
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                last_grant_d = owner_q;
                state_d      = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Registered so the datapath reset is low for exactly the CLEAR cycle.
        dp_aresetn_d = (state_d != CLEAR);
    end

endmodule

// File: tb/tb_demod_arbiter.sv
// Directed bench for demod_arbiter: two channel sources, a 1-cycle datapath model
// and a monitor recording every accepted beat with its cycle number.
module tb_demod_arbiter;

    localparam int DATA_W = 32;

    logic              clk;
    logic              rst_n;
    logic              s00_axis_tvalid, s00_axis_tready, s00_axis_tlast;
    logic [DATA_W-1:0] s00_axis_tdata;
    logic              s01_axis_tvalid, s01_axis_tready, s01_axis_tlast;
    logic [DATA_W-1:0] s01_axis_tdata;
    logic              m00_axis_tvalid, m00_axis_tready, m00_axis_tlast;
    logic [DATA_W-1:0] m00_axis_tdata;
    logic              s02_axis_tvalid, s02_axis_tready, s02_axis_tlast;
    logic [DATA_W-1:0] s02_axis_tdata;
    logic              m01_axis_tvalid, m01_axis_tready, m01_axis_tlast, m01_axis_tuser;
    logic [DATA_W-1:0] m01_axis_tdata;
    logic              dp_aresetn;

    int n_checks = 0;
    int n_fails  = 0;
    int cyc      = 0;

    logic [32:0] ch0_q[$];
    logic [32:0] ch1_q[$];
    logic [32:0] dp_q[$];

    logic [31:0] m00_dq[$];
    logic        m00_oq[$];
    logic        m00_lq[$];
    int          m00_cq[$];
    logic [31:0] m01_dq[$];
    logic        m01_uq[$];
    logic        m01_lq[$];
    int          m01_cq[$];
    int          dp_low_cq[$];
    int          viol_cnt;

    demod_arbiter #(.DATA_W(DATA_W)) dut (
        .s00_axis_aclk   (clk),
        .s00_axis_aresetn(rst_n),
        .s00_axis_tvalid (s00_axis_tvalid),
        .s00_axis_tready (s00_axis_tready),
        .s00_axis_tdata  (s00_axis_tdata),
        .s00_axis_tlast  (s00_axis_tlast),
        .s01_axis_tvalid (s01_axis_tvalid),
        .s01_axis_tready (s01_axis_tready),
        .s01_axis_tdata  (s01_axis_tdata),
        .s01_axis_tlast  (s01_axis_tlast),
        .m00_axis_tvalid (m00_axis_tvalid),
        .m00_axis_tready (m00_axis_tready),
        .m00_axis_tdata  (m00_axis_tdata),
        .m00_axis_tlast  (m00_axis_tlast),
        .s02_axis_tvalid (s02_axis_tvalid),
        .s02_axis_tready (s02_axis_tready),
        .s02_axis_tdata  (s02_axis_tdata),
        .s02_axis_tlast  (s02_axis_tlast),
        .m01_axis_tvalid (m01_axis_tvalid),
        .m01_axis_tready (m01_axis_tready),
        .m01_axis_tdata  (m01_axis_tdata),
        .m01_axis_tlast  (m01_axis_tlast),
        .m01_axis_tuser  (m01_axis_tuser),
        .dp_aresetn      (dp_aresetn)
    );

    // Clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Channel sources present the head of their queue, refreshed on the falling edge.
    always @(negedge clk) begin
        logic [32:0] t;
        s00_axis_tvalid = (ch0_q.size() != 0);
        if (ch0_q.size() != 0) begin
            t = ch0_q[0];
            s00_axis_tdata = t[31:0];
            s00_axis_tlast = t[32];
        end
        s01_axis_tvalid = (ch1_q.size() != 0);
        if (ch1_q.size() != 0) begin
            t = ch1_q[0];
            s01_axis_tdata = t[31:0];
            s01_axis_tlast = t[32];
        end
    end

    // Monitor, source pops and 1-cycle datapath model (flushed by dp_aresetn).
    always @(posedge clk) begin
        logic [32:0] t;
        if (rst_n) begin
            if (m00_axis_tvalid && m00_axis_tready) begin
                m00_dq.push_back(m00_axis_tdata);
                m00_oq.push_back(s01_axis_tready);
                m00_lq.push_back(m00_axis_tlast);
                m00_cq.push_back(cyc);
            end
            if (m01_axis_tvalid && m01_axis_tready) begin
                m01_dq.push_back(m01_axis_tdata);
                m01_uq.push_back(m01_axis_tuser);
                m01_lq.push_back(m01_axis_tlast);
                m01_cq.push_back(cyc);
            end
            if (!dp_aresetn) dp_low_cq.push_back(cyc);
            if (s00_axis_tready && s01_axis_tready) viol_cnt++;
            if (s00_axis_tvalid && s00_axis_tready && ch0_q.size() != 0) void'(ch0_q.pop_front());
            if (s01_axis_tvalid && s01_axis_tready && ch1_q.size() != 0) void'(ch1_q.pop_front());
        end
        if (!dp_aresetn) begin
            dp_q.delete();
        end else begin
            if (s02_axis_tvalid && s02_axis_tready && dp_q.size() != 0) void'(dp_q.pop_front());
            if (m00_axis_tvalid && m00_axis_tready) dp_q.push_back({m00_axis_tlast, m00_axis_tdata});
        end
        if (dp_q.size() != 0) begin
            t = dp_q[0];
            s02_axis_tvalid <= 1'b1;
            s02_axis_tdata  <= t[31:0];
            s02_axis_tlast  <= t[32];
        end else begin
            s02_axis_tvalid <= 1'b0;
        end
        cyc++;
    end

    // Driver tasks
    task automatic push_ch(input int ch, input logic [31:0] d, input logic l);
        if (ch == 0) ch0_q.push_back({l, d});
        else         ch1_q.push_back({l, d});
    endtask

    task automatic clear_mon();
        m00_dq.delete(); m00_oq.delete(); m00_lq.delete(); m00_cq.delete();
        m01_dq.delete(); m01_uq.delete(); m01_lq.delete(); m01_cq.delete();
        dp_low_cq.delete();
        viol_cnt = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        ch0_q.delete();
        ch1_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        clear_mon();
    endtask

    task automatic wait_m01(input int n, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (m01_dq.size() >= n) break;
            @(negedge clk);
        end
    endtask

    task automatic wait_m00(input int n, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (m00_dq.size() >= n) break;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        m00_axis_tready = 1'b1;
        m01_axis_tready = 1'b1;
        s02_axis_tvalid = 1'b0;
        s02_axis_tdata  = '0;
        s02_axis_tlast  = 1'b0;
        #12;
        n_checks++; if (s00_axis_tready !== 1'b0) begin n_fails++; $display("FAIL reset_s00_tready got %b want 0", s00_axis_tready); end
        n_checks++; if (s01_axis_tready !== 1'b0) begin n_fails++; $display("FAIL reset_s01_tready got %b want 0", s01_axis_tready); end
        n_checks++; if (m00_axis_tvalid !== 1'b0) begin n_fails++; $display("FAIL reset_m00_tvalid got %b want 0", m00_axis_tvalid); end
        n_checks++; if (m01_axis_tvalid !== 1'b0) begin n_fails++; $display("FAIL reset_m01_tvalid got %b want 0", m01_axis_tvalid); end
        n_checks++; if (m01_axis_tuser !== 1'b0) begin n_fails++; $display("FAIL reset_tuser got %b want 0", m01_axis_tuser); end
        n_checks++; if (dp_aresetn !== 1'b0) begin n_fails++; $display("FAIL reset_dp_aresetn got %b want 0", dp_aresetn); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++; if (dp_aresetn !== 1'b1) begin n_fails++; $display("FAIL reset_release_dp_aresetn got %b want 1", dp_aresetn); end
        @(negedge clk);
        clear_mon();
    endtask

    task automatic test_basic();
        logic [31:0] exp_d [4] = '{32'h1000, 32'h2000, 32'h3000, 32'h4000};
        for (int i = 0; i < 4; i++) push_ch(0, exp_d[i], i == 3);
        push_ch(0, 32'h5000, 1'b0);
        push_ch(0, 32'h6000, 1'b1);
        wait_m01(6, 100);
        repeat (4) @(negedge clk);
        n_checks++; if (m00_dq.size() !== 6) begin n_fails++; $display("FAIL basic_m00_count got %0d want 6", m00_dq.size()); end
        n_checks++; if (m01_dq.size() !== 6) begin n_fails++; $display("FAIL basic_m01_count got %0d want 6", m01_dq.size()); end
        if (m00_dq.size() == 6 && m01_dq.size() == 6) begin
            for (int i = 0; i < 4; i++) begin
                n_checks++; if (m00_dq[i] !== exp_d[i] || m00_oq[i] !== 1'b0 || m00_lq[i] !== (i == 3))
                    begin n_fails++; $display("FAIL basic_m00_beat%0d got %h/o%b/l%b want %h/o0/l%b", i, m00_dq[i], m00_oq[i], m00_lq[i], exp_d[i], i == 3); end
                n_checks++; if (m01_dq[i] !== exp_d[i] || m01_uq[i] !== 1'b0 || m01_lq[i] !== (i == 3))
                    begin n_fails++; $display("FAIL basic_m01_beat%0d got %h/u%b/l%b want %h/u0/l%b", i, m01_dq[i], m01_uq[i], m01_lq[i], exp_d[i], i == 3); end
            end
            n_checks++; if (dp_low_cq.size() !== 2) begin n_fails++; $display("FAIL basic_dp_low_cycles got %0d want 2", dp_low_cq.size()); end
            if (dp_low_cq.size() != 0) begin
                n_checks++; if (dp_low_cq[0] !== m01_cq[3] + 1) begin n_fails++; $display("FAIL basic_clear_cycle got %0d want %0d", dp_low_cq[0], m01_cq[3] + 1); end
            end
            n_checks++; if (m00_cq[4] !== m01_cq[3] + 3) begin n_fails++; $display("FAIL basic_next_grant got %0d want %0d", m00_cq[4], m01_cq[3] + 3); end
            n_checks++; if (m01_dq[5] !== 32'h6000 || m01_lq[5] !== 1'b1) begin n_fails++; $display("FAIL basic_second_pkt got %h/l%b want 6000/l1", m01_dq[5], m01_lq[5]); end
        end
        clear_mon();
    endtask

    task automatic test_alternate();
        logic [31:0] e;
        int pkt, ch;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            push_ch(0, 32'hA000_0000 + i, (i % 3) == 2);
            push_ch(1, 32'hB000_0000 + i, (i % 3) == 2);
        end
        wait_m01(12, 300);
        repeat (4) @(negedge clk);
        n_checks++; if (m00_dq.size() !== 12 || m01_dq.size() !== 12)
            begin n_fails++; $display("FAIL alt_counts got %0d/%0d want 12/12", m00_dq.size(), m01_dq.size()); end
        if (m00_dq.size() == 12 && m01_dq.size() == 12) begin
            for (int i = 0; i < 12; i++) begin
                pkt = i / 3;
                ch  = pkt % 2;
                e   = (ch == 1 ? 32'hB000_0000 : 32'hA000_0000) + 32'((pkt / 2) * 3 + i % 3);
                n_checks++; if (m00_dq[i] !== e || m00_oq[i] !== ch[0])
                    begin n_fails++; $display("FAIL alt_m00_beat%0d got %h/o%b want %h/o%b", i, m00_dq[i], m00_oq[i], e, ch[0]); end
                n_checks++; if (m01_dq[i] !== e || m01_uq[i] !== ch[0] || m01_lq[i] !== ((i % 3) == 2))
                    begin n_fails++; $display("FAIL alt_m01_beat%0d got %h/u%b/l%b want %h/u%b", i, m01_dq[i], m01_uq[i], m01_lq[i], e, ch[0]); end
            end
        end
        n_checks++; if (viol_cnt !== 0) begin n_fails++; $display("FAIL alt_both_ready got %0d want 0", viol_cnt); end
        clear_mon();
    endtask

    task automatic test_drain_request();
        m01_axis_tready = 1'b0;
        push_ch(0, 32'hD000_0000, 1'b0);
        push_ch(0, 32'hD000_0001, 1'b1);
        wait_m00(2, 50);
        push_ch(1, 32'hE000_0000, 1'b1);
        repeat (4) @(negedge clk);
        n_checks++; if (m00_dq.size() !== 2) begin n_fails++; $display("FAIL drain_no_early_grant got %0d want 2", m00_dq.size()); end
        m01_axis_tready = 1'b1;
        wait_m01(3, 100);
        repeat (4) @(negedge clk);
        n_checks++; if (m00_dq.size() !== 3 || m01_dq.size() !== 3 || dp_low_cq.size() !== 2)
            begin n_fails++; $display("FAIL drain_counts got %0d/%0d/%0d want 3/3/2", m00_dq.size(), m01_dq.size(), dp_low_cq.size()); end
        if (m00_dq.size() == 3 && m01_dq.size() == 3 && dp_low_cq.size() == 2) begin
            n_checks++; if (m00_dq[2] !== 32'hE000_0000 || m00_oq[2] !== 1'b1)
                begin n_fails++; $display("FAIL drain_ch1_beat got %h/o%b want e0000000/o1", m00_dq[2], m00_oq[2]); end
            n_checks++; if (m00_cq[2] !== dp_low_cq[0] + 2)
                begin n_fails++; $display("FAIL drain_after_clear got %0d want %0d", m00_cq[2], dp_low_cq[0] + 2); end
            n_checks++; if (m00_cq[2] !== m01_cq[1] + 3)
                begin n_fails++; $display("FAIL drain_gap got %0d want %0d", m00_cq[2], m01_cq[1] + 3); end
            n_checks++; if (m01_uq[2] !== 1'b1) begin n_fails++; $display("FAIL drain_tuser got %b want 1", m01_uq[2]); end
        end
        clear_mon();
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 4; i++) push_ch(0, 32'hC0DE_0000 + i, i == 3);
        wait_m01(2, 50);
        m01_axis_tready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            n_checks++; if (s02_axis_tready !== 1'b0) begin n_fails++; $display("FAIL bp_s02_ready_c%0d got %b want 0", i, s02_axis_tready); end
            @(negedge clk);
        end
        m01_axis_tready = 1'b1;
        wait_m01(4, 50);
        repeat (4) @(negedge clk);
        n_checks++; if (m01_dq.size() !== 4) begin n_fails++; $display("FAIL bp_count got %0d want 4", m01_dq.size()); end
        if (m01_dq.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                n_checks++; if (m01_dq[i] !== 32'hC0DE_0000 + i || m01_lq[i] !== (i == 3))
                    begin n_fails++; $display("FAIL bp_beat%0d got %h/l%b want %h", i, m01_dq[i], m01_lq[i], 32'hC0DE_0000 + i); end
            end
        end
        clear_mon();
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 4; i++) push_ch(0, 32'h9000_0000 + i, i == 3);
        wait_m00(1, 50);
        #2;
        rst_n = 1'b0;
        ch0_q.delete();
        ch1_q.delete();
        #1;
        n_checks++; if (s00_axis_tready !== 1'b0 || s01_axis_tready !== 1'b0 || s02_axis_tready !== 1'b0)
            begin n_fails++; $display("FAIL arst_readys got %b%b%b want 000", s00_axis_tready, s01_axis_tready, s02_axis_tready); end
        n_checks++; if (m00_axis_tvalid !== 1'b0 || m01_axis_tvalid !== 1'b0)
            begin n_fails++; $display("FAIL arst_valids got %b%b want 00", m00_axis_tvalid, m01_axis_tvalid); end
        n_checks++; if (m01_axis_tuser !== 1'b0 || dp_aresetn !== 1'b0)
            begin n_fails++; $display("FAIL arst_tuser_dp got %b/%b want 0/0", m01_axis_tuser, dp_aresetn); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        clear_mon();
        push_ch(0, 32'h1111_0000, 1'b1);
        push_ch(1, 32'h2222_0000, 1'b1);
        wait_m01(2, 50);
        repeat (4) @(negedge clk);
        n_checks++; if (m00_dq.size() !== 2) begin n_fails++; $display("FAIL arst_tie_count got %0d want 2", m00_dq.size()); end
        if (m00_dq.size() == 2) begin
            n_checks++; if (m00_oq[0] !== 1'b0 || m00_dq[0] !== 32'h1111_0000)
                begin n_fails++; $display("FAIL arst_tie_first got %h/o%b want 11110000/o0", m00_dq[0], m00_oq[0]); end
            n_checks++; if (m00_oq[1] !== 1'b1) begin n_fails++; $display("FAIL arst_tie_second got o%b want o1", m00_oq[1]); end
        end
        clear_mon();
    endtask

    task automatic test_one_beat();
        int p;
        @(posedge clk);
        #1;
        p = cyc;
        push_ch(1, 32'h7777_0001, 1'b1);
        wait_m01(1, 50);
        repeat (4) @(negedge clk);
        n_checks++; if (m00_dq.size() !== 1 || m01_dq.size() !== 1 || dp_low_cq.size() !== 1)
            begin n_fails++; $display("FAIL one_counts got %0d/%0d/%0d want 1/1/1", m00_dq.size(), m01_dq.size(), dp_low_cq.size()); end
        if (m00_dq.size() == 1 && m01_dq.size() == 1 && dp_low_cq.size() == 1) begin
            n_checks++; if (m00_cq[0] !== p + 1) begin n_fails++; $display("FAIL one_grant_latency got %0d want %0d", m00_cq[0], p + 1); end
            n_checks++; if (m00_oq[0] !== 1'b1 || m00_lq[0] !== 1'b1)
                begin n_fails++; $display("FAIL one_m00 got o%b/l%b want o1/l1", m00_oq[0], m00_lq[0]); end
            n_checks++; if (m01_dq[0] !== 32'h7777_0001 || m01_uq[0] !== 1'b1 || m01_lq[0] !== 1'b1)
                begin n_fails++; $display("FAIL one_m01 got %h/u%b/l%b want 77770001/u1/l1", m01_dq[0], m01_uq[0], m01_lq[0]); end
            n_checks++; if (m01_cq[0] !== m00_cq[0] + 1) begin n_fails++; $display("FAIL one_drain_cycle got %0d want %0d", m01_cq[0], m00_cq[0] + 1); end
            n_checks++; if (dp_low_cq[0] !== m01_cq[0] + 1) begin n_fails++; $display("FAIL one_clear_cycle got %0d want %0d", dp_low_cq[0], m01_cq[0] + 1); end
        end
        clear_mon();
        push_ch(0, 32'h8888_0000, 1'b1);
        push_ch(1, 32'h8888_0001, 1'b1);
        wait_m01(2, 50);
        repeat (4) @(negedge clk);
        n_checks++; if (m00_oq.size() !== 2) begin n_fails++; $display("FAIL one_tie_count got %0d want 2", m00_oq.size()); end
        if (m00_oq.size() == 2) begin
            n_checks++; if (m00_oq[0] !== 1'b0) begin n_fails++; $display("FAIL one_last_grant_tie got o%b want o0", m00_oq[0]); end
        end
        clear_mon();
    endtask

    initial begin
        ch0_q.delete();
        ch1_q.delete();
        s00_axis_tvalid = 1'b0; s00_axis_tdata = '0; s00_axis_tlast = 1'b0;
        s01_axis_tvalid = 1'b0; s01_axis_tdata = '0; s01_axis_tlast = 1'b0;
        viol_cnt = 0;
        test_reset();
        test_basic();
        test_alternate();
        test_drain_request();
        test_backpressure();
        test_async_reset();
        test_one_beat();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
